// File: rtl/coreUtils.sv
// Core-wide constants and helpers shared by pipeline stages.
// Combinational only.
package coreUtils;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // bypass supplies an absolute target (bit0 dropped); otherwise PC-relative
  function automatic logic [31:0] redirectTarget(input logic        bypass,
                                                 input logic [31:0] pcNext,
                                                 input logic [31:0] pcCurrent);
    return bypass ? {pcNext[31:1], 1'b0} : pcCurrent + pcNext;
  endfunction

endpackage

// File: rtl/core_types_pkg.sv
// Shared core types: branch-unit redirect bundle and fetch FSM state encoding.
// Pure type definitions, no logic.
package core_types_pkg;

  typedef struct packed {
    logic        flush;
    logic        hold;
    logic        branch;
    logic        bypass;
    logic [31:0] PCnext;
    logic [31:0] PCcurrent;
  } branching_out_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    HELD
  } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer parking a fetched word while decode holds; 1-cycle load-to-valid.
// clear beats load beats pop; no backpressure of its own (caller loads only when empty).
module fetch_skid_buf (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        load,
  input  logic [31:0] loadData,
  input  logic        pop,
  input  logic        clear,
  output logic [31:0] data,
  output logic        valid
);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= loadData;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch FSM: one outstanding request, 2 cycles/instr best case, all outputs registered.
// hold freezes the IF outputs (late response parked in skid); redirect preempts hold and responses.
module fetch_unit
  import core_types_pkg::*;
  import coreUtils::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic           Clock,
  input  logic           nReset,
  input  branching_out_t redirect,
  output logic           imem_req,
  output logic [31:0]    imem_addr,
  input  logic           imem_ready,
  input  logic           imem_rvalid,
  input  logic [31:0]    imem_rdata,
  output logic [31:0]    PCIF,
  output logic [31:0]    instrIF,
  output logic           validIF,
  output logic           misaligned
);

  fetch_state_t state;
  logic [31:0]  pc;
  logic [31:0]  rawTarget;
  logic [31:0]  target;
  logic [31:0]  skidData;
  logic         skidValid;
  logic         doRedirect;
  logic         skidLoad;
  logic         skidPop;
  logic         toDrain;

  assign doRedirect = redirect.branch | redirect.bypass;
  assign rawTarget  = redirectTarget(redirect.bypass, redirect.PCnext, redirect.PCcurrent);
  assign target     = {rawTarget[31:2], 2'b00};
  assign skidLoad   = (state == WAIT) && imem_rvalid && redirect.hold && !doRedirect;
  assign skidPop    = (state == HELD) && !redirect.hold && !doRedirect;

  // A request still in flight after this edge must have its response swallowed
  assign toDrain = ((state == WAIT)  && !imem_rvalid) ||
                   ((state == REQ)   && imem_ready)   ||
                   ((state == DRAIN) && !imem_rvalid);

  fetch_skid_buf skidBuf (
    .Clock    (Clock),
    .nReset   (nReset),
    .load     (skidLoad),
    .loadData (imem_rdata),
    .pop      (skidPop),
    .clear    (doRedirect),
    .data     (skidData),
    .valid    (skidValid)
  );

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state      <= IDLE;
      pc         <= RESET_VECTOR;
      imem_req   <= 1'b0;
      imem_addr  <= '0;
      PCIF       <= '0;
      instrIF    <= NOP;
      validIF    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      misaligned <= doRedirect && (rawTarget[1:0] != 2'b00);
      if (!redirect.hold) validIF <= 1'b0;

      if (doRedirect) begin
        pc      <= target;
        validIF <= 1'b0;
        if (toDrain) begin
          state    <= DRAIN;
          imem_req <= 1'b0;
        end else begin
          state     <= REQ;
          imem_req  <= 1'b1;
          imem_addr <= target;
        end
      end else begin
        case (state)
          IDLE: begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= pc;
          end
          REQ: begin
            if (imem_ready) begin
              state    <= WAIT;
              imem_req <= 1'b0;
            end
          end
          WAIT: begin
            if (imem_rvalid) begin
              if (redirect.hold) begin
                state <= HELD;
              end else begin
                instrIF   <= imem_rdata;
                PCIF      <= pc;
                validIF   <= 1'b1;
                pc        <= pc + 32'd4;
                state     <= REQ;
                imem_req  <= 1'b1;
                imem_addr <= pc + 32'd4;
              end
            end
          end
          DRAIN: begin
            if (imem_rvalid) begin
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc;
            end
          end
          HELD: begin
            if (!redirect.hold) begin
              instrIF   <= skidData;
              PCIF      <= pc;
              validIF   <= skidValid;
              pc        <= pc + 32'd4;
              state     <= REQ;
              imem_req  <= 1'b1;
              imem_addr <= pc + 32'd4;
            end
          end
          default: state <= IDLE;
        endcase
        if (redirect.flush) validIF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed cycle-by-cycle vectors for fetch_unit plus a reset-during-WAIT sequence.
module tb_fetch_unit;
  import core_types_pkg::*;

  logic           Clock;
  logic           nReset;
  branching_out_t redirect;
  logic           imem_req;
  logic [31:0]    imem_addr;
  logic           imem_ready;
  logic           imem_rvalid;
  logic [31:0]    imem_rdata;
  logic [31:0]    PCIF;
  logic [31:0]    instrIF;
  logic           validIF;
  logic           misaligned;

  int passed = 0;
  int total  = 0;

  fetch_unit dut (
    .Clock       (Clock),
    .nReset      (nReset),
    .redirect    (redirect),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .PCIF        (PCIF),
    .instrIF     (instrIF),
    .validIF     (validIF),
    .misaligned  (misaligned)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ctl = {hold, flush, branch, bypass}; mem = {ready, rvalid}; exp = {req, valid, misaligned}
  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] pcNext;
    logic [31:0] pcCur;
    logic [1:0]  mem;
    logic [31:0] rdata;
    logic [2:0]  exp;
    logic [31:0] eAddr;
    logic [31:0] ePC;
    logic [31:0] eInstr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] ctl, input logic [31:0] pcNext, input logic [31:0] pcCur,
                     input logic [1:0] mem, input logic [31:0] rdata, input logic [2:0] exp,
                     input logic [31:0] eAddr, input logic [31:0] ePC, input logic [31:0] eInstr);
    vec_t v;
    v.ctl = ctl; v.pcNext = pcNext; v.pcCur = pcCur; v.mem = mem; v.rdata = rdata;
    v.exp = exp; v.eAddr = eAddr; v.ePC = ePC; v.eInstr = eInstr;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [31:0] pcNext, input logic [31:0] pcCur,
                       input logic [1:0] mem, input logic [31:0] rdata);
    redirect.hold      = ctl[3];
    redirect.flush     = ctl[2];
    redirect.branch    = ctl[1];
    redirect.bypass    = ctl[0];
    redirect.PCnext    = pcNext;
    redirect.PCcurrent = pcCur;
    imem_ready         = mem[1];
    imem_rvalid        = mem[0];
    imem_rdata         = rdata;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic checkAll(input string tag, input logic [2:0] exp, input logic [31:0] eAddr,
                          input logic [31:0] ePC, input logic [31:0] eInstr);
    check({tag, " imem_req"},   32'(imem_req),   32'(exp[2]));
    check({tag, " imem_addr"},  imem_addr,       eAddr);
    check({tag, " validIF"},    32'(validIF),    32'(exp[1]));
    check({tag, " PCIF"},       PCIF,            ePC);
    check({tag, " instrIF"},    instrIF,         eInstr);
    check({tag, " misaligned"}, 32'(misaligned), 32'(exp[0]));
  endtask

  initial begin
    // startup and sequential fetch (rvalid in IDLE must be ignored)
    add(4'b0000, 32'h0,   32'h0,   2'b11, 32'hBAD0, 3'b100, 32'h0,   32'h0,   32'h13);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h0,   32'h0,   32'h13);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hA0,   3'b110, 32'h4,   32'h0,   32'hA0);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h4,   32'h0,   32'hA0);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hA4,   3'b110, 32'h8,   32'h4,   32'hA4);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h8,   32'h4,   32'hA4);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hA8,   3'b110, 32'hC,   32'h8,   32'hA8);
    // branch in WAIT -> DRAIN, response dropped, refetch at 0x120
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'hC,   32'h8,   32'hA8);
    add(4'b0010, 32'h20,  32'h100, 2'b00, 32'h0,    3'b000, 32'hC,   32'h8,   32'hA8);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hBAD1, 3'b100, 32'h120, 32'h8,   32'hA8);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h120, 32'h8,   32'hA8);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hB0,   3'b110, 32'h124, 32'h120, 32'hB0);
    // bypass+branch with misaligned target, in REQ not accepted
    add(4'b0011, 32'h203, 32'h100, 2'b00, 32'h0,    3'b101, 32'h200, 32'h120, 32'hB0);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h200, 32'h120, 32'hB0);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hC0,   3'b110, 32'h204, 32'h200, 32'hC0);
    // flush overrides a held valid; PC unaffected
    add(4'b1100, 32'h0,   32'h0,   2'b00, 32'h0,    3'b100, 32'h204, 32'h200, 32'hC0);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h204, 32'h200, 32'hC0);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hC4,   3'b110, 32'h208, 32'h204, 32'hC4);
    // hold for three cycles while the response arrives
    add(4'b1000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b010, 32'h208, 32'h204, 32'hC4);
    add(4'b1000, 32'h0,   32'h0,   2'b01, 32'hDEADBEEF, 3'b010, 32'h208, 32'h204, 32'hC4);
    add(4'b1000, 32'h0,   32'h0,   2'b00, 32'h0,    3'b010, 32'h208, 32'h204, 32'hC4);
    add(4'b0000, 32'h0,   32'h0,   2'b00, 32'h0,    3'b110, 32'h20C, 32'h208, 32'hDEADBEEF);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h20C, 32'h208, 32'hDEADBEEF);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hD0,   3'b110, 32'h210, 32'h20C, 32'hD0);
    // redirect beats hold and a same-cycle response
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h210, 32'h20C, 32'hD0);
    add(4'b1010, 32'h30,  32'h10,  2'b01, 32'hE0,   3'b100, 32'h40,  32'h20C, 32'hD0);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h40,  32'h20C, 32'hD0);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hE4,   3'b110, 32'h44,  32'h40,  32'hE4);
    // redirect out of HELD discards the parked word
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h44,  32'h40,  32'hE4);
    add(4'b1000, 32'h0,   32'h0,   2'b01, 32'h5A,   3'b000, 32'h44,  32'h40,  32'hE4);
    add(4'b1001, 32'h80,  32'h0,   2'b00, 32'h0,    3'b100, 32'h80,  32'h40,  32'hE4);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h80,  32'h40,  32'hE4);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hF0,   3'b110, 32'h84,  32'h80,  32'hF0);
    // second redirect while draining updates PC only
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h84,  32'h80,  32'hF0);
    add(4'b0010, 32'h4,   32'h1000, 2'b00, 32'h0,   3'b000, 32'h84,  32'h80,  32'hF0);
    add(4'b0001, 32'h3000, 32'h0,  2'b00, 32'h0,    3'b000, 32'h84,  32'h80,  32'hF0);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'hBAD2, 3'b100, 32'h3000, 32'h80, 32'hF0);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h3000, 32'h80, 32'hF0);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'h11,   3'b110, 32'h3004, 32'h3000, 32'h11);
    // PC wraps modulo 2^32
    add(4'b0001, 32'hFFFFFFFC, 32'h0, 2'b00, 32'h0, 3'b100, 32'hFFFFFFFC, 32'h3000, 32'h11);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'hFFFFFFFC, 32'h3000, 32'h11);
    add(4'b0000, 32'h0,   32'h0,   2'b01, 32'h22,   3'b110, 32'h0,   32'hFFFFFFFC, 32'h22);
    add(4'b0000, 32'h0,   32'h0,   2'b10, 32'h0,    3'b000, 32'h0,   32'hFFFFFFFC, 32'h22);

    nReset = 1'b0;
    drive(4'b0000, 32'h0, 32'h0, 2'b00, 32'h0);
    repeat (2) @(negedge Clock);
    checkAll("reset", 3'b000, 32'h0, 32'h0, 32'h13);
    nReset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ctl, vecs[i].pcNext, vecs[i].pcCur, vecs[i].mem, vecs[i].rdata);
      @(posedge Clock);
      #1;
      checkAll($sformatf("row%0d", i), vecs[i].exp, vecs[i].eAddr, vecs[i].ePC, vecs[i].eInstr);
      @(negedge Clock);
    end

    // reset while a request is outstanding; late response must not be taken
    nReset = 1'b0;
    #1;
    checkAll("midreset", 3'b000, 32'h0, 32'h0, 32'h13);
    @(negedge Clock);
    nReset = 1'b1;
    drive(4'b0000, 32'h0, 32'h0, 2'b01, 32'hBAD3);
    @(posedge Clock); #1;
    checkAll("stale1", 3'b100, 32'h0, 32'h0, 32'h13);
    @(negedge Clock);
    drive(4'b0000, 32'h0, 32'h0, 2'b01, 32'hBAD3);
    @(posedge Clock); #1;
    checkAll("stale2", 3'b100, 32'h0, 32'h0, 32'h13);
    @(negedge Clock);
    drive(4'b0000, 32'h0, 32'h0, 2'b10, 32'h0);
    @(posedge Clock); #1;
    checkAll("refetch", 3'b000, 32'h0, 32'h0, 32'h13);
    @(negedge Clock);
    drive(4'b0000, 32'h0, 32'h0, 2'b01, 32'h99);
    @(posedge Clock); #1;
    checkAll("firstword", 3'b110, 32'h4, 32'h0, 32'h99);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named Clock and nReset.
REQ-002 Port list (name  direction  width  meaning):
- Clock  in  1  rising-edge clock.
- nReset  in  1  asynchronous active-low reset.
- redirect  in  branching_out_t  flush/hold/branch/bypass/PCnext/PCcurrent from the branch unit.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch byte address.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid.
- imem_rdata  in  32  fetched instruction.
- PCIF  out  32  PC of the instruction presented to decode.
- instrIF  out  32  instruction presented to decode.
- validIF  out  1  PCIF/instrIF hold a live instruction.
- misaligned  out  1  one-cycle pulse when a redirect target had bits[1:0] != 0.
REQ-003 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL give the first fetch address.

Function
REQ-004 States SHALL be IDLE, REQ, WAIT, DRAIN and HELD, with at most one memory request outstanding.
REQ-005 IDLE SHALL last exactly one cycle after reset release, then move to REQ; imem_rvalid SHALL be ignored in IDLE.
REQ-006 In REQ, the block SHALL assert imem_req with imem_addr = PC; on imem_ready it SHALL move to WAIT.
REQ-007 In WAIT with imem_rvalid and no hold, the block SHALL register instrIF <= imem_rdata, PCIF <= PC, validIF <= 1 and PC <= PC+4 (mod 2^32), then move to REQ.
REQ-008 In WAIT with imem_rvalid and hold=1, the block SHALL capture imem_rdata into a one-entry skid buffer and move to HELD; IF outputs stay frozen.
REQ-009 In HELD, the block SHALL issue no request; on the first cycle with hold=0, it SHALL load the skid entry to the IF outputs as in REQ-007 and move to REQ.
REQ-010 When hold=1 without redirect, PCIF, instrIF and validIF SHALL remain unchanged.
REQ-011 A redirect occurs when branch=1 or bypass=1; the target SHALL be PCnext with bit0 cleared if bypass=1, else PCcurrent+PCnext mod 2^32.
REQ-012 If bypass and branch are both 1, bypass SHALL win.
REQ-013 A target with bits[1:0] != 0 SHALL be fetched with bits[1:0] forced to 00, and misaligned SHALL pulse for one cycle.
REQ-014 Redirect response:
- PC <= target and validIF <= 0 next cycle.
- The skid buffer SHALL be discarded.
- Redirect SHALL take priority over hold and over a same-cycle imem_rvalid.
REQ-015 A redirect in WAIT (or in REQ with imem_ready=1) SHALL move to DRAIN; in IDLE/REQ-not-accepted/HELD it SHALL move to REQ.
REQ-016 In DRAIN, the block SHALL issue no request and SHALL discard the next imem_rvalid, then move to REQ; a further redirect in DRAIN SHALL update PC only.
REQ-017 flush=1 without redirect SHALL set validIF <= 0 next cycle and SHALL leave PC and state unchanged.
REQ-018 Best-case throughput SHALL be one instruction per two cycles (REQ, WAIT), with no combinational path from redirect to imem_req.

Reset
REQ-019 On nReset low, the block SHALL go to state IDLE with PC = RESET_VECTOR, PCIF = 0, instrIF = 32'h0000_0013 (NOP), validIF = 0, imem_req = 0, imem_addr = 0, misaligned = 0 and the skid buffer empty.
REQ-020 Reset mid-request SHALL abandon the outstanding transaction; any late imem_rvalid SHALL be ignored per REQ-005.

Structure
REQ-021 fetch_state_t SHALL live in core_types_pkg alongside the existing branching_out_t; the NOP encoding SHALL live in coreUtils.
REQ-022 The skid buffer SHALL be a sub-module named fetch_skid_buf (data, valid, load, pop, clear).

Verification
REQ-023 Reset release, imem_ready=1, rvalid one cycle after accept -> addresses 0x0, 0x4, 0x8 and validIF pulses with PCIF = 0x0, 0x4, 0x8.
REQ-024 branch=1, PCcurrent=0x100, PCnext=0x20 in WAIT -> DRAIN; next rvalid dropped; next imem_addr = 0x120; validIF = 0.
REQ-025 bypass=1, PCnext=0x203, with branch=1 also set -> imem_addr = 0x200 and misaligned pulses once.
REQ-026 hold=1 for 3 cycles while rvalid arrives with 0xDEADBEEF -> no imem_req; IF outputs frozen; on release instrIF = 0xDEADBEEF.
REQ-027 flush=1 alone -> validIF = 0 next cycle; PC sequence continues unbroken.
REQ-028 nReset asserted in WAIT, stale rvalid 2 cycles after release -> ignored; first fetch at RESET_VECTOR.
